instr_fetch_stage: RTL

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared widths, constants and entry types for the fetch stage
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] MISALIGN_MASK     = 32'h0000_0003;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            misalign;
  } trk_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } buf_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & MISALIGN_MASK) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : small power-of-two FIFO with occupancy count and bulk clear
// Rev 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = CNT_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// instr_fetch_stage : credit-limited instruction fetch with flush discard
// Rev 1.0
// ============================================================================
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            id_misalign,
  output logic            proto_err
);

  localparam int              CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]  CAPACITY = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             proto_err_q, proto_err_d;
  logic             credit;
  logic             rsp_accept;
  logic             buf_push;
  logic             buf_pop;
  trk_entry_t       trk_push_data, trk_head;
  buf_entry_t       buf_push_data, buf_head;

  // Only registered occupancy feeds credit, so a pop frees a slot one cycle later.
  assign credit     = ({1'b0, inflight} + {1'b0, count}) < CAPACITY;
  assign imem_req   = pc_valid & credit & ~flush & ~rst;
  assign imem_addr  = pc_in & ~MISALIGN_MASK;
  assign pc_ready   = imem_req & imem_gnt;

  assign rsp_accept = imem_rvalid & (inflight != '0);
  assign buf_push   = rsp_accept & (discard_q == '0) & ~flush;
  assign id_valid   = (count != '0);
  assign buf_pop    = id_valid & id_ready & ~flush;

  assign trk_push_data.pc       = pc_in;
  assign trk_push_data.misalign = is_misaligned(pc_in);

  assign buf_push_data.instr    = imem_rdata;
  assign buf_push_data.pc       = trk_head.pc;
  assign buf_push_data.misalign = trk_head.misalign;

  fetch_fifo #(
    .WIDTH ($bits(trk_entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (pc_ready),
    .push_data (trk_push_data),
    .pop       (rsp_accept),
    .head_data (trk_head),
    .count     (inflight)
  );

  fetch_fifo #(
    .WIDTH ($bits(buf_entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (count)
  );

  // Requests still in flight at a flush must be drained and thrown away.
  always_comb begin
    discard_d = discard_q;
    if (flush) begin
      discard_d = inflight - CNT_W'(rsp_accept);
    end else if (rsp_accept && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
  end

  assign proto_err_d = proto_err_q | (imem_rvalid & (inflight == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      discard_q   <= discard_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    id_instr    = NOP_INSTR;
    id_pc       = '0;
    id_pc_plus4 = '0;
    id_misalign = 1'b0;
    if (id_valid) begin
      id_instr    = buf_head.instr;
      id_pc       = buf_head.pc;
      id_pc_plus4 = buf_head.pc + XLEN'(4);
      id_misalign = buf_head.misalign;
    end
  end

  assign proto_err = proto_err_q;

endmodule
`default_nettype wire
